// File: rtl/hilo_muldiv32.sv
// HI/LO multiply/divide unit: iterative radix-2 mult/multu/div/divu
// plus mfhi/mflo/mthi/mtlo, with a stall for HI/LO ops while busy.
module hilo_muldiv32 #(
    parameter logic [31:0] DBZ_LO = 32'hFFFFFFFF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] Instruction,
    input  logic        issue,
    input  logic [31:0] read_data_1,
    input  logic [31:0] read_data_2,
    output logic [31:0] hilo_result,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        stall
);
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

    state_t      r_state;
    state_t      w_next;
    logic [4:0]  r_cnt;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [63:0] r_acc;
    logic [63:0] r_mcand;
    logic [31:0] r_b;
    logic [32:0] r_rem;
    logic [31:0] r_quo;
    logic        r_is_div;
    logic        r_neg_q;
    logic        r_neg_r;
    logic        r_dbz;

    logic [5:0]  w_funct;
    logic        w_special;
    logic        w_mult;
    logic        w_multu;
    logic        w_div;
    logic        w_divu;
    logic        w_mfhi;
    logic        w_mflo;
    logic        w_mthi;
    logic        w_mtlo;
    logic        w_sgn;
    logic        w_is_hilo;
    logic        w_accept;
    logic        w_start_mul;
    logic        w_start_div;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [32:0] w_trial;
    logic [33:0] w_sub;
    logic [63:0] w_prod;
    logic        w_unused;

    assign w_funct   = Instruction[5:0];
    assign w_special = (Instruction[31:26] == 6'h00);
    assign w_mult    = w_special & (w_funct == 6'h18);
    assign w_multu   = w_special & (w_funct == 6'h19);
    assign w_div     = w_special & (w_funct == 6'h1A);
    assign w_divu    = w_special & (w_funct == 6'h1B);
    assign w_mfhi    = w_special & (w_funct == 6'h10);
    assign w_mthi    = w_special & (w_funct == 6'h11);
    assign w_mflo    = w_special & (w_funct == 6'h12);
    assign w_mtlo    = w_special & (w_funct == 6'h13);
    assign w_sgn     = w_mult | w_div;
    assign w_is_hilo = w_mult | w_multu | w_div | w_divu |
                       w_mfhi | w_mthi | w_mflo | w_mtlo;

    assign w_accept    = issue & (r_state == S_IDLE);
    assign w_start_mul = w_accept & (w_mult | w_multu);
    assign w_start_div = w_accept & (w_div | w_divu);

    assign w_abs_a = (w_sgn & read_data_1[31]) ? -read_data_1 : read_data_1;
    assign w_abs_b = (w_sgn & read_data_2[31]) ? -read_data_2 : read_data_2;

    // Dividend bits shift out of r_quo's top as quotient bits enter its bottom
    assign w_trial = {r_rem[31:0], r_quo[31]};
    assign w_sub   = {1'b0, w_trial} - {2'b00, r_b};
    assign w_prod  = r_neg_q ? -r_acc : r_acc;

    assign hi          = r_hi;
    assign lo          = r_lo;
    assign busy        = (r_state != S_IDLE);
    assign stall       = issue & w_is_hilo & busy;
    assign hilo_result = w_mfhi ? r_hi : (w_mflo ? r_lo : 32'h0);
    assign w_unused    = ^{Instruction[25:6], r_rem[32]};

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_start_mul)
                    w_next = S_MUL;
                else if (w_start_div)
                    w_next = S_DIV;
            end
            S_MUL, S_DIV: begin
                if (r_cnt == 5'd31)
                    w_next = S_FIX;
            end
            S_FIX:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt    <= 5'd0;
            r_hi     <= 32'h0;
            r_lo     <= 32'h0;
            r_acc    <= 64'h0;
            r_mcand  <= 64'h0;
            r_b      <= 32'h0;
            r_rem    <= 33'h0;
            r_quo    <= 32'h0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_dbz    <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    r_cnt <= 5'd0;
                    if (w_start_mul | w_start_div) begin
                        r_is_div <= w_start_div;
                        r_neg_q  <= w_sgn & (read_data_1[31] ^ read_data_2[31]);
                        r_neg_r  <= w_sgn & read_data_1[31];
                        r_dbz    <= w_start_div & (read_data_2 == 32'h0);
                        r_acc    <= 64'h0;
                        r_mcand  <= {32'h0, w_abs_a};
                        r_b      <= w_abs_b;
                        r_rem    <= 33'h0;
                        r_quo    <= w_abs_a;
                    end else if (w_accept & w_mthi) begin
                        r_hi <= read_data_1;
                    end else if (w_accept & w_mtlo) begin
                        r_lo <= read_data_1;
                    end
                end
                S_MUL: begin
                    r_cnt <= r_cnt + 5'd1;
                    if (r_b[0])
                        r_acc <= r_acc + r_mcand;
                    r_mcand <= r_mcand << 1;
                    r_b     <= {1'b0, r_b[31:1]};
                end
                S_DIV: begin
                    r_cnt <= r_cnt + 5'd1;
                    if (!w_sub[33]) begin
                        r_rem <= w_sub[32:0];
                        r_quo <= {r_quo[30:0], 1'b1};
                    end else begin
                        r_rem <= w_trial;
                        r_quo <= {r_quo[30:0], 1'b0};
                    end
                end
                S_FIX: begin
                    // A zero divisor leaves |rs| as remainder, so HI restores rs
                    if (r_is_div) begin
                        r_hi <= r_neg_r ? -r_rem[31:0] : r_rem[31:0];
                        r_lo <= r_dbz ? DBZ_LO : (r_neg_q ? -r_quo : r_quo);
                    end else begin
                        r_hi <= w_prod[63:32];
                        r_lo <= w_prod[31:0];
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/hilo_muldiv32.md
Name: hilo_muldiv32

Overview:
- Execute-side multiply/divide unit that sits directly downstream of the decode/register-file stage.
- Consumes the decoded Instruction and the two register operands, read_data_1 (rs) and read_data_2 (rt).
- Implements MIPS mult/multu/div/divu with iterative radix-2 datapaths.
- Owns the HI/LO architectural registers, serves mfhi/mflo/mthi/mtlo, and raises a stall when a HI/LO instruction hits a busy unit.

Parameters:
- DBZ_LO, 32'hFFFFFFFF, LO value written on divide-by-zero (HI gets the dividend).

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- Instruction  input  32  current instruction; opcode [31:26], funct [5:0].
- issue  input  1  instruction is valid and retiring this cycle (not frozen).
- read_data_1  input  32  rs operand (multiplicand / dividend / mthi-mtlo source).
- read_data_2  input  32  rt operand (multiplier / divisor).
- hilo_result  output  32  mfhi→HI, mflo→LO, otherwise 0; combinational.
- hi  output  32  current HI register.
- lo  output  32  current LO register.
- busy  output  1  multi-cycle operation in flight.
- stall  output  1  freeze PC and retire; combinational.

Behaviour:
- Decode: an op is a HI/LO op only when opcode==6'h00. Funct codes:
  - 6'h18 mult, 6'h19 multu, 6'h1A div, 6'h1B divu
  - 6'h10 mfhi, 6'h11 mthi, 6'h12 mflo, 6'h13 mtlo
- Reset: HI=0, LO=0, state=IDLE, busy=0, counter=0, internal accumulators=0. Reset mid-operation aborts the operation; no HI/LO update occurs.
- State machine: IDLE, MUL, DIV, FIX.
  - IDLE, issue & mult/multu: capture operand magnitudes (abs for signed) and result-sign bits → MUL. For div/divu → DIV. Counter=0.
  - MUL: shift-add one multiplier bit per cycle into a 64-bit product. After 32 iterations (counter==31) → FIX.
  - DIV: restoring divide, one quotient bit per cycle, 33-bit partial remainder. After 32 iterations → FIX.
  - FIX: apply sign fixup and write HI/LO on this edge → IDLE.
    - Signed mult: negate the 64-bit product if the operand signs differ.
    - Signed div: quotient negative if the signs differ; remainder takes the dividend's sign.
- Latency: op accepted in cycle N.
  - busy=1 in cycles N+1..N+33 (32 iteration cycles + FIX).
  - HI/LO are written at the end of cycle N+33 and visible from cycle N+34.
- Divide by zero (divisor==0, div or divu): HI=rs, LO=DBZ_LO, with the same 33-cycle latency.
- Signed overflow: 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- Mult results: multu gives the 64-bit unsigned product; mult gives the 64-bit two's-complement product. HI=[63:32], LO=[31:0].
- mthi/mtlo in IDLE with issue: write rs to HI/LO at the end of the cycle.
- mfhi/mflo: hilo_result reflects the current register value; no forwarding from same-cycle writes.
- stall = issue & is_hilo_op & (state!=IDLE).
  - Any HI/LO instruction, including a new mult/div, is held while busy and is not accepted.
  - It is accepted in the first cycle state==IDLE, i.e. cycle N+34.
  - Non-HI/LO instructions never stall and proceed in parallel with an in-flight operation.
- Operands are captured only at acceptance; later changes to read_data_1/2 during busy are ignored.
- issue=0 gives no state change in IDLE (frozen instruction is not accepted). An in-flight operation continues regardless of issue.
- Simultaneous reset and issue: reset wins; nothing is accepted.

Test Plan:
- Signed mult: reset, then mult rs=0xFFFFFFFD (-3), rt=7 → busy 33 cycles. From N+34: HI=0xFFFFFFFF, LO=0xFFFFFFEB, busy=0.
- Unsigned mult: multu rs=rt=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001. Then mflo gives hilo_result=0x00000001 with stall=0.
- Signed div and overflow: div rs=0xFFFFFFF9 (-7), rt=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then div 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- Divide by zero: divu rs=0x64, rt=0 → HI=0x00000064, LO=0xFFFFFFFF after 33 busy cycles.
- Stall and parallel issue:
  - mult accepted at N; an unrelated addu issued at N+1 gives stall=0.
  - mfhi issued and held from N+2 gives stall=1 through N+33, then 0 at N+34 with hilo_result equal to the new HI.
  - A div held at N+5 is accepted only at N+34.
- Move ops and reset abort:
  - mthi 0x12345678 then mfhi → 0x12345678.
  - Start div, assert reset at N+10 → busy=0, HI=LO=0 the next cycle, and no late write occurs at N+33.
